// File: rtl/rx_mac.sv
// rtl/rx_mac.sv - receive-side Ethernet MAC: preamble/SFD strip, FCS check/strip, AXI-Stream out
//
// Purpose: accepts one byte per cycle from the PHY adapter, hunts for preamble + SFD,
// delays the frame through a 4-byte hold register so the FCS never reaches the stream,
// checks CRC-32, and reports frame status on tuser of the tlast beat.
//
// Ports:
//   clk                 clock, rx data sampled on rising edge
//   reset               asynchronous active-high reset
//   rgmii_mac_rx_data   received byte
//   rgmii_mac_rx_dv     byte valid (preamble..FCS)
//   rgmii_mac_rx_er     PHY receive error for current byte
//   m_rx_axis_tdata     payload byte
//   m_rx_axis_tvalid    beat valid
//   m_rx_axis_tlast     last payload byte of frame
//   m_rx_axis_tuser     on tlast beat: 1 = frame bad
//   m_rx_axis_trdy      downstream ready
//   rx_good_frames / rx_bad_frames / rx_drop_frames
//                       32-bit saturating frame counters, present only when
//                       RX_MAC_STATS_EN is defined
module rx_mac #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
  input  logic                  rgmii_mac_rx_dv,
  input  logic                  rgmii_mac_rx_er,
  output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
  output logic                  m_rx_axis_tvalid,
  output logic                  m_rx_axis_tlast,
  output logic                  m_rx_axis_tuser,
  input  logic                  m_rx_axis_trdy
`ifdef RX_MAC_STATS_EN
  ,
  output logic [31:0]           rx_good_frames,
  output logic [31:0]           rx_bad_frames,
  output logic [31:0]           rx_drop_frames
`endif
);

  localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'('h55);
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'('hD5);
  localparam logic [31:0]           CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]           CRC_GOOD = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
    S_END,
    S_DROP
  } state_t;

  state_t state, state_nxt;

  // input sampling stage
  logic [DATA_WIDTH-1:0] data_r;
  logic                  dv_r;
  logic                  er_r;
  // cleared by reset, set once dv has been seen low; keeps a reset landing
  // mid-frame from locking onto a stray 0x55 inside that frame
  logic                  armed;

  // FCS hold register: hold[3] is the oldest byte once hold_cnt reaches 4
  logic [DATA_WIDTH-1:0] hold [4];
  logic [2:0]            hold_cnt;
  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_valid;

  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [15:0] len;
  logic        er_flag;
  logic        ovf_flag;
  logic        pending_end;

  // output register
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_user;

  // combinational control
  logic                  push;
  logic                  issue;
  logic                  issue_last;
  logic                  issue_user;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_user;
  logic                  out_free;
  logic                  frame_bad;
  logic                  end_blocked;
  logic                  runt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c ^ {{(32-DATA_WIDTH){1'b0}}, d};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_nxt     = crc_byte(crc, data_r);
  assign runt        = (len < 16'(MIN_FRAME_LEN));
  assign frame_bad   = (crc != CRC_GOOD) | er_flag | runt | ovf_flag;
  assign out_free    = !out_valid || m_rx_axis_trdy;
  assign end_blocked = issue && issue_last && !out_free;

  always_comb begin
    state_nxt  = state;
    push       = (state == S_PAYLOAD) && dv_r;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_user = 1'b0;
    load       = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    load_user  = 1'b0;

    // the candidate is only known to be non-last once another byte arrives
    if (push && cand_valid) begin
      issue = 1'b1;
    end
    if (state == S_END && cand_valid) begin
      issue      = 1'b1;
      issue_last = 1'b1;
      issue_user = frame_bad;
    end

    if (issue) begin
      if (out_free) begin
        load      = 1'b1;
        load_data = cand;
        load_last = issue_last;
        load_user = issue_user;
      end
    end else if (pending_end && out_free) begin
      // substitute terminator for a tlast beat lost to overflow
      load      = 1'b1;
      load_data = '0;
      load_last = 1'b1;
      load_user = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (armed && dv_r) begin
          state_nxt = (data_r == PRE_BYTE && !pending_end) ? S_PREAMBLE : S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!dv_r) begin
          state_nxt = S_DROP;
        end else if (data_r == SFD_BYTE) begin
          state_nxt = S_PAYLOAD;
        end else if (data_r != PRE_BYTE) begin
          state_nxt = S_DROP;
        end
      end
      S_PAYLOAD: begin
        if (!dv_r) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        // a new frame may start in the same cycle the tlast beat goes out
        if (dv_r) begin
          state_nxt = (data_r == PRE_BYTE && !pending_end && !end_blocked) ? S_PREAMBLE : S_DROP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!dv_r) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      data_r      <= '0;
      dv_r        <= 1'b0;
      er_r        <= 1'b0;
      armed       <= 1'b0;
      hold        <= '{default: '0};
      hold_cnt    <= '0;
      cand        <= '0;
      cand_valid  <= 1'b0;
      crc         <= CRC_INIT;
      len         <= '0;
      er_flag     <= 1'b0;
      ovf_flag    <= 1'b0;
      pending_end <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_user    <= 1'b0;
    end else begin
      data_r <= rgmii_mac_rx_data;
      dv_r   <= rgmii_mac_rx_dv;
      er_r   <= rgmii_mac_rx_er;
      armed  <= armed | ~rgmii_mac_rx_dv;
      state  <= state_nxt;

      if (state == S_PREAMBLE && state_nxt == S_PAYLOAD) begin
        hold_cnt   <= '0;
        cand_valid <= 1'b0;
        crc        <= CRC_INIT;
        len        <= '0;
        er_flag    <= 1'b0;
        ovf_flag   <= 1'b0;
      end else if (push) begin
        hold[3] <= hold[2];
        hold[2] <= hold[1];
        hold[1] <= hold[0];
        hold[0] <= data_r;
        if (hold_cnt == 3'd4) begin
          cand       <= hold[3];
          cand_valid <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 3'd1;
        end
        crc     <= crc_nxt;
        er_flag <= er_flag | er_r;
        if (len != 16'hFFFF) begin
          len <= len + 16'd1;
        end
      end else if (state == S_END) begin
        cand_valid <= 1'b0;
      end

      if (issue && !out_free && !issue_last) begin
        ovf_flag <= 1'b1;
      end

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_last  <= load_last;
        out_user  <= load_user;
      end else if (m_rx_axis_trdy) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_user  <= 1'b0;
      end

      if (end_blocked) begin
        pending_end <= 1'b1;
      end else if (load && !issue) begin
        pending_end <= 1'b0;
      end
    end
  end

  assign m_rx_axis_tdata  = out_data;
  assign m_rx_axis_tvalid = out_valid;
  assign m_rx_axis_tlast  = out_last;
  assign m_rx_axis_tuser  = out_user;

`ifdef RX_MAC_STATS_EN
  logic enter_drop;
  assign enter_drop = (state_nxt == S_DROP) && (state != S_DROP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_good_frames <= '0;
      rx_bad_frames  <= '0;
      rx_drop_frames <= '0;
    end else begin
      if (load && load_last && !load_user && rx_good_frames != 32'hFFFF_FFFF) begin
        rx_good_frames <= rx_good_frames + 32'd1;
      end
      if (load && load_last && load_user && rx_bad_frames != 32'hFFFF_FFFF) begin
        rx_bad_frames <= rx_bad_frames + 32'd1;
      end
      if (enter_drop && rx_drop_frames != 32'hFFFF_FFFF) begin
        rx_drop_frames <= rx_drop_frames + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_mac.sv
// tb/tb_rx_mac.sv - directed self-checking bench for rx_mac
module tb_rx_mac;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       trdy;
`ifdef RX_MAC_STATS_EN
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;
  logic [31:0] drop_cnt;
`endif

  int compared;
  int mismatched;

  logic [7:0] pay[$];
  logic [7:0] rd[$];
  logic       rl[$];
  logic       ru[$];
  int         vseen;

  rx_mac #(.DATA_WIDTH(8), .MIN_FRAME_LEN(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .rgmii_mac_rx_data (rx_data),
    .rgmii_mac_rx_dv   (rx_dv),
    .rgmii_mac_rx_er   (rx_er),
    .m_rx_axis_tdata   (tdata),
    .m_rx_axis_tvalid  (tvalid),
    .m_rx_axis_tlast   (tlast),
    .m_rx_axis_tuser   (tuser),
    .m_rx_axis_trdy    (trdy)
`ifdef RX_MAC_STATS_EN
    ,
    .rx_good_frames    (good_cnt),
    .rx_bad_frames     (bad_cnt),
    .rx_drop_frames    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // beat is recorded at the negedge before the posedge that accepts it
  always @(negedge clk) begin
    if (!reset) begin
      if (tvalid) vseen++;
      if (tvalid && trdy) begin
        rd.push_back(tdata);
        rl.push_back(tlast);
        ru.push_back(tuser);
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic int count_last();
    int c = 0;
    foreach (rl[i]) if (rl[i]) c++;
    return c;
  endfunction

  task automatic clear_mon();
    rd.delete(); rl.delete(); ru.delete(); vseen = 0;
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(posedge clk); #1;
    rx_data = d; rx_dv = v; rx_er = e;
  endtask

  task automatic make_ramp(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(i));
  endtask

  task automatic send_frame(input int npre, input logic [7:0] sfd, input int er_idx,
                            input bit flip, input int idle_after);
    logic [31:0] c;
    logic [7:0]  b[$];
    c = 32'hFFFF_FFFF;
    foreach (pay[i]) c = crc_upd(c, pay[i]);
    c = ~c;
    b = pay;
    b.push_back(c[7:0]); b.push_back(c[15:8]); b.push_back(c[23:16]); b.push_back(c[31:24]);
    if (flip) b[b.size()-1] = b[b.size()-1] ^ 8'h10;
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(sfd, 1'b1, 1'b0);
    foreach (b[i]) drive(b[i], 1'b1, (i == er_idx));
    for (int i = 0; i < idle_after; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_last(input int n, input int budget);
    int k = 0;
    while (count_last() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 8'h00; rx_dv = 1'b0; rx_er = 1'b0; trdy = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    compared++; if (tlast !== 1'b0) begin mismatched++; $display("FAIL reset_tlast got %b want 0", tlast); end
    compared++; if (tuser !== 1'b0) begin mismatched++; $display("FAIL reset_tuser got %b want 0", tuser); end
    compared++; if (tdata !== 8'h00) begin mismatched++; $display("FAIL reset_tdata got %h want 00", tdata); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("FAIL idle_tvalid got %b want 0", tvalid); end
  endtask

  task automatic test_good_frame();
    clear_mon();
    make_ramp(60);
    send_frame(7, 8'hD5, -1, 1'b0, 3);
    wait_last(1, 100);
    compared++; if (rd.size() !== 60) begin mismatched++; $display("FAIL good_count got %0d want 60", rd.size()); end
    for (int i = 0; i < rd.size(); i++) begin
      compared++;
      if (rd[i] !== 8'(i) || rl[i] !== (i == 59)) begin
        mismatched++;
        $display("FAIL good_beat%0d got %h/%b want %h/%b", i, rd[i], rl[i], 8'(i), (i == 59));
      end
    end
    if (rd.size() > 0) begin
      compared++; if (ru[ru.size()-1] !== 1'b0) begin mismatched++; $display("FAIL good_tuser got 1 want 0"); end
    end
  endtask

  task automatic test_bad_crc();
    clear_mon();
    make_ramp(60);
    send_frame(7, 8'hD5, -1, 1'b1, 3);
    wait_last(1, 100);
    compared++; if (rd.size() !== 60) begin mismatched++; $display("FAIL badcrc_count got %0d want 60", rd.size()); end
    compared++; if (count_last() !== 1) begin mismatched++; $display("FAIL badcrc_tlast got %0d want 1", count_last()); end
    if (rd.size() > 0) begin
      compared++; if (ru[ru.size()-1] !== 1'b1) begin mismatched++; $display("FAIL badcrc_tuser got 0 want 1"); end
    end
  endtask

  task automatic test_rx_er();
    clear_mon();
    make_ramp(60);
    send_frame(7, 8'hD5, 10, 1'b0, 3);
    wait_last(1, 100);
    compared++; if (rd.size() !== 60) begin mismatched++; $display("FAIL rxer_count got %0d want 60", rd.size()); end
    if (rd.size() > 0) begin
      compared++; if (ru[ru.size()-1] !== 1'b1) begin mismatched++; $display("FAIL rxer_tuser got 0 want 1"); end
      compared++; if (rl[rl.size()-1] !== 1'b1) begin mismatched++; $display("FAIL rxer_tlast got 0 want 1"); end
    end
  endtask

  task automatic test_bad_preamble();
`ifdef RX_MAC_STATS_EN
    logic [31:0] drop0;
    drop0 = drop_cnt;
`endif
    clear_mon();
    make_ramp(60);
    send_frame(2, 8'hA5, -1, 1'b0, 3);
    repeat (20) @(posedge clk);
    compared++; if (vseen !== 0) begin mismatched++; $display("FAIL badpre_tvalid got %0d want 0", vseen); end
`ifdef RX_MAC_STATS_EN
    compared++; if (drop_cnt !== drop0 + 32'd1) begin mismatched++; $display("FAIL badpre_dropcnt got %0d want %0d", drop_cnt, drop0 + 1); end
`endif
  endtask

  task automatic test_backpressure();
    clear_mon();
    make_ramp(96);
    fork
      send_frame(7, 8'hD5, -1, 1'b0, 3);
      begin
        int k;
        k = 0;
        while (!tvalid && k < 300) begin @(negedge clk); k++; end
        repeat (20) @(posedge clk);
        #1 trdy = 1'b0;
        repeat (11) @(posedge clk);
        #1 trdy = 1'b1;
      end
    join
    wait_last(1, 200);
    compared++; if (count_last() !== 1) begin mismatched++; $display("FAIL bp_tlast got %0d want 1", count_last()); end
    compared++; if (rd.size() >= 96) begin mismatched++; $display("FAIL bp_count got %0d want <96", rd.size()); end
    if (rd.size() > 0) begin
      compared++; if (rl[rl.size()-1] !== 1'b1) begin mismatched++; $display("FAIL bp_lastflag got 0 want 1"); end
      compared++; if (ru[ru.size()-1] !== 1'b1) begin mismatched++; $display("FAIL bp_tuser got 0 want 1"); end
      compared++; if (rd[rd.size()-1] !== 8'h5F) begin mismatched++; $display("FAIL bp_lastdata got %h want 5f", rd[rd.size()-1]); end
    end
  endtask

  task automatic test_runt();
    clear_mon();
    make_ramp(26);
    send_frame(7, 8'hD5, -1, 1'b0, 3);
    wait_last(1, 100);
    compared++; if (rd.size() !== 26) begin mismatched++; $display("FAIL runt_count got %0d want 26", rd.size()); end
    if (rd.size() > 0) begin
      compared++; if (ru[ru.size()-1] !== 1'b1) begin mismatched++; $display("FAIL runt_tuser got 0 want 1"); end
      compared++; if (rd[rd.size()-1] !== 8'h19) begin mismatched++; $display("FAIL runt_lastdata got %h want 19", rd[rd.size()-1]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    make_ramp(10);
    send_frame(7, 8'hD5, -1, 1'b0, 1);
    make_ramp(60);
    send_frame(7, 8'hD5, -1, 1'b0, 3);
    wait_last(2, 200);
    compared++; if (rd.size() !== 70) begin mismatched++; $display("FAIL b2b_count got %0d want 70", rd.size()); end
    if (rd.size() == 70) begin
      compared++; if (rl[9] !== 1'b1 || ru[9] !== 1'b1) begin mismatched++; $display("FAIL b2b_first got %b/%b want 1/1", rl[9], ru[9]); end
      compared++; if (rl[69] !== 1'b1 || ru[69] !== 1'b0) begin mismatched++; $display("FAIL b2b_second got %b/%b want 1/0", rl[69], ru[69]); end
      compared++; if (rd[10] !== 8'h00 || rd[69] !== 8'h3B) begin mismatched++; $display("FAIL b2b_data got %h/%h want 00/3b", rd[10], rd[69]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    make_ramp(60);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(8'(i), 1'b1, 1'b0);
    #2 reset = 1'b1;
    #2;
    compared++; if (tvalid !== 1'b0) begin mismatched++; $display("FAIL midrst_tvalid got %b want 0", tvalid); end
    compared++; if (tdata !== 8'h00) begin mismatched++; $display("FAIL midrst_tdata got %h want 00", tdata); end
    @(posedge clk); #1 reset = 1'b0;
    clear_mon();
    // remainder of the aborted frame, including preamble-looking bytes
    for (int i = 0; i < 30; i++) drive((i % 3 == 0) ? 8'h55 : 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
    send_frame(7, 8'hD5, -1, 1'b0, 3);
    wait_last(1, 100);
    compared++; if (count_last() !== 1) begin mismatched++; $display("FAIL midrst_tlast got %0d want 1", count_last()); end
    compared++; if (rd.size() !== 60) begin mismatched++; $display("FAIL midrst_count got %0d want 60", rd.size()); end
    if (rd.size() > 0) begin
      compared++; if (rd[0] !== 8'h00) begin mismatched++; $display("FAIL midrst_first got %h want 00", rd[0]); end
      compared++; if (ru[ru.size()-1] !== 1'b0) begin mismatched++; $display("FAIL midrst_tuser got 1 want 0"); end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    vseen = 0;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_rx_er();
    test_bad_preamble();
    test_backpressure();
    test_runt();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
